// File: rtl/gray_counter_param_pkg.sv
// Shared constants and Gray-code helpers for counters and FIFO pointer logic.
package gray_counter_param_pkg;

  localparam int unsigned MAX_WIDTH = 16;
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Binary to Gray over the widest supported count; callers cast to their width.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_param_gray2bin_conv.sv
// Combinational Gray to binary decoder built as an XOR prefix chain from the MSB down.
module gray2bin_conv #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Bin_c
);

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    Bin_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      Bin_c[i] = ^(Gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with load, wrap/saturate mode, sticky overflow and terminal-count pulse.
module gray_counter_param
  import gray_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned SATURATE  = MODE_WRAP,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadGray,
  input  logic             En,
  input  logic             Up,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Count,
  output logic             Overflow,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_WIDTH'(RESET_VAL)));

  logic [WIDTH-1:0] load_bin_c;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             ovf_nxt;
  logic             tc_nxt;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_dec (
    .Gray  (LoadGray),
    .Bin_c (load_bin_c)
  );

  // Next-state selection: Clr beats Load beats En; boundary attempts flag overflow and pulse Tc.
  always_comb begin
    count_nxt = Count;
    ovf_nxt   = Overflow;
    tc_nxt    = 1'b0;
    if (Clr) begin
      count_nxt = RST_BIN;
      ovf_nxt   = 1'b0;
    end else if (Load) begin
      count_nxt = load_bin_c;
    end else if (En) begin
      if (Up) begin
        if (Count == MAX_VAL) begin
          ovf_nxt   = 1'b1;
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
        end else begin
          count_nxt = Count + WIDTH'(1);
        end
      end else begin
        if (Count == '0) begin
          ovf_nxt   = 1'b1;
          tc_nxt    = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          count_nxt = Count - WIDTH'(1);
        end
      end
    end
    gray_nxt = WIDTH'(bin2gray(MAX_WIDTH'(count_nxt)));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Count    <= RST_BIN;
      Output   <= RST_GRAY;
      Overflow <= 1'b0;
      Tc       <= 1'b0;
    end else begin
      Count    <= count_nxt;
      Output   <= gray_nxt;
      Overflow <= ovf_nxt;
      Tc       <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: wrap (W=3), saturate (W=3) and wrap (W=4) instances.
module tb_gray_counter_param;

  typedef struct {
    int         id;
    int         seq;
    logic [3:0] cnt;
    logic [3:0] gry;
    logic       ovf;
    logic       tc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n;
  logic clr [3];
  logic load[3];
  logic en  [3];
  logic up  [3];
  logic [3:0] lg;

  logic [2:0] out_a, cnt_a, out_b, cnt_b;
  logic [3:0] out_c, cnt_c;
  logic       ovf_a, tc_a, ovf_b, tc_b, ovf_c, tc_c;

  logic [3:0] act_cnt[3];
  logic [3:0] act_gry[3];
  logic       act_ovf[3];
  logic       act_tc [3];

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_no   = 0;

  always #5 Clk = ~Clk;

  gray_counter_param #(.WIDTH(3), .SATURATE(0), .RESET_VAL(0)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(clr[0]), .Load(load[0]), .LoadGray(lg[2:0]),
    .En(en[0]), .Up(up[0]), .Output(out_a), .Count(cnt_a), .Overflow(ovf_a), .Tc(tc_a));

  gray_counter_param #(.WIDTH(3), .SATURATE(1), .RESET_VAL(0)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(clr[1]), .Load(load[1]), .LoadGray(lg[2:0]),
    .En(en[1]), .Up(up[1]), .Output(out_b), .Count(cnt_b), .Overflow(ovf_b), .Tc(tc_b));

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) dut_c (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(clr[2]), .Load(load[2]), .LoadGray(lg),
    .En(en[2]), .Up(up[2]), .Output(out_c), .Count(cnt_c), .Overflow(ovf_c), .Tc(tc_c));

  assign act_cnt[0] = {1'b0, cnt_a};
  assign act_gry[0] = {1'b0, out_a};
  assign act_ovf[0] = ovf_a;
  assign act_tc[0]  = tc_a;
  assign act_cnt[1] = {1'b0, cnt_b};
  assign act_gry[1] = {1'b0, out_b};
  assign act_ovf[1] = ovf_b;
  assign act_tc[1]  = tc_b;
  assign act_cnt[2] = cnt_c;
  assign act_gry[2] = out_c;
  assign act_ovf[2] = ovf_c;
  assign act_tc[2]  = tc_c;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, "_count"}, act_cnt[e.id], e.cnt);
    chk({tag, "_gray"},  act_gry[e.id], e.gry);
    chk({tag, "_ovf"},   {3'b000, act_ovf[e.id]}, {3'b000, e.ovf});
    chk({tag, "_tc"},    {3'b000, act_tc[e.id]},  {3'b000, e.tc});
  endtask

  // Monitor: every rising edge, compare the oldest expected entry against its DUT.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_all($sformatf("dut%0d_step%0d", e.id, e.seq), e);
    end
  end

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; load[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b0;
    end
    lg = 4'b0000;
  endtask

  // Drive one cycle of stimulus on DUT id and queue the expected post-edge state.
  task automatic step(input int id, input logic c, input logic l, input logic [3:0] g,
                      input logic e, input logic u, input logic [3:0] ecnt,
                      input logic [3:0] egry, input logic eovf, input logic etc);
    exp_t x;
    @(negedge Clk);
    idle_inputs();
    clr[id] = c; load[id] = l; en[id] = e; up[id] = u; lg = g;
    x.id = id; x.seq = seq_no; x.cnt = ecnt; x.gry = egry; x.ovf = eovf; x.tc = etc;
    seq_no++;
    sb.push_back(x);
  endtask

  task automatic direct(input string tag, input int id, input logic [3:0] ecnt,
                        input logic [3:0] egry, input logic eovf, input logic etc);
    exp_t x;
    x.id = id; x.seq = 0; x.cnt = ecnt; x.gry = egry; x.ovf = eovf; x.tc = etc;
    chk_all(tag, x);
  endtask

  initial begin
    logic [3:0] g3[8];
    g3[0] = 4'b0000; g3[1] = 4'b0001; g3[2] = 4'b0011; g3[3] = 4'b0010;
    g3[4] = 4'b0110; g3[5] = 4'b0111; g3[6] = 4'b0101; g3[7] = 4'b0100;

    idle_inputs();
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    for (int d = 0; d < 3; d++) direct($sformatf("reset_dut%0d", d), d, 4'd0, 4'b0000, 1'b0, 1'b0);
    Reset_n = 1'b1;

    // Wrap mode W=3: 9 up-steps, wrap on the 8th.
    for (int i = 1; i < 8; i++) step(0, 0, 0, 4'b0, 1, 1, 4'(i), g3[i], 1'b0, 1'b0);
    step(0, 0, 0, 4'b0, 1, 1, 4'd0, 4'b0000, 1'b1, 1'b1);
    step(0, 0, 0, 4'b0, 1, 1, 4'd1, 4'b0001, 1'b1, 1'b0);

    // Saturate mode W=3: 10 up-steps, sticks at 7 with Tc every cycle.
    for (int i = 1; i < 8; i++) step(1, 0, 0, 4'b0, 1, 1, 4'(i), g3[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 4'b0, 1, 1, 4'd7, 4'b0100, 1'b1, 1'b1);
    // Clr with Load while Overflow=1: Clr wins.
    step(1, 1, 1, 4'b0110, 1, 1, 4'd0, 4'b0000, 1'b0, 1'b0);

    // W=4: underflow, clear, underflow again, load, count, hold.
    step(2, 0, 0, 4'b0, 1, 0, 4'd15, 4'b1000, 1'b1, 1'b1);
    step(2, 1, 0, 4'b0, 0, 0, 4'd0,  4'b0000, 1'b0, 1'b0);
    step(2, 0, 0, 4'b0, 1, 0, 4'd15, 4'b1000, 1'b1, 1'b1);
    step(2, 0, 1, 4'b1101, 1, 1, 4'd9, 4'b1101, 1'b1, 1'b0);
    step(2, 0, 0, 4'b0, 1, 1, 4'd10, 4'b1111, 1'b1, 1'b0);
    step(2, 0, 0, 4'b0, 0, 1, 4'd10, 4'b1111, 1'b1, 1'b0);

    // Advance W=3 wrap instance from 1 to 5, then reset mid-cycle.
    for (int i = 2; i < 6; i++) step(0, 0, 0, 4'b0, 1, 1, 4'(i), g3[i], 1'b1, 1'b0);
    @(negedge Clk);
    idle_inputs();
    #2 Reset_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) direct($sformatf("async_rst_dut%0d", d), d, 4'd0, 4'b0000, 1'b0, 1'b0);
    #1 Reset_n = 1'b1;
    step(0, 0, 0, 4'b0, 1, 1, 4'd1, 4'b0001, 1'b0, 1'b0);

    @(negedge Clk);
    idle_inputs();
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge Clk);
    if (sb.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
